// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the accumulator datapath: walks FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, times out stalled memory accesses and tracks call depth.
module multicycle_control_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] opcode,
    input  logic       sel,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       addr_pc,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       load_A,
    output logic       load_B,
    output logic       wb_A,
    output logic       wr_mem,
    output logic       imm,
    output logic       jmp,
    output logic       ret,
    output logic       push,
    output logic       pop,
    output logic       instr_done,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [2:0] OP_LOAD_A   = 3'b000;
    localparam logic [2:0] OP_LOAD_B   = 3'b001;
    localparam logic [2:0] OP_LOAD_IMM = 3'b010;
    localparam logic [2:0] OP_STORE    = 3'b011;
    localparam logic [2:0] OP_JMP      = 3'b100;
    localparam logic [2:0] OP_RET      = 3'b110;
    localparam logic [2:0] OP_ALU      = 3'b111;

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_STACK   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    logic [2:0]    state, state_d;
    logic [DW-1:0] depth;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    op_q;
    logic          sel_q;
    logic          fault_q;
    logic [1:0]    fault_code_q, code_d;
    logic          waiting, timeout_hit;

    // A request is outstanding in FETCH (when enabled) and in every MEM cycle.
    assign waiting     = (state == S_FETCH && en) || (state == S_MEM);
    assign timeout_hit = waiting && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        code_d  = 2'b00;
        case (state)
            S_FETCH: begin
                if (en) begin
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (timeout_hit) begin
                        state_d = S_FAULT;
                        code_d  = FC_TIMEOUT;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD_A, OP_LOAD_B, OP_STORE: state_d = S_MEM;
                    OP_LOAD_IMM:                    state_d = S_WB;
                    OP_ALU:                         state_d = S_EXEC;
                    OP_JMP: begin
                        if (depth < DW'(STACK_DEPTH)) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_FAULT;
                            code_d  = FC_STACK;
                        end
                    end
                    OP_RET: begin
                        if (depth != '0) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_FAULT;
                            code_d  = FC_STACK;
                        end
                    end
                    default: begin
                        state_d = S_FAULT;
                        code_d  = FC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: state_d = (op_q == OP_ALU) ? S_WB : S_FETCH;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                    code_d  = FC_TIMEOUT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FETCH;
            depth        <= '0;
            wait_cnt     <= '0;
            op_q         <= 3'b000;
            sel_q        <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state <= state_d;
            if (state_d == S_FAULT && state != S_FAULT) begin
                fault_q      <= 1'b1;
                fault_code_q <= code_d;
            end
            if (state == S_DECODE) begin
                op_q  <= opcode;
                sel_q <= sel;
            end
            if (state == S_EXEC && op_q == OP_JMP)
                depth <= depth + DW'(1);
            else if (state == S_EXEC && op_q == OP_RET)
                depth <= depth - DW'(1);
            // Counter restarts on every fresh entry to a waiting state and while idle.
            if (state == S_FETCH && !en)
                wait_cnt <= '0;
            else if (state_d != state && (state_d == S_FETCH || state_d == S_MEM))
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        mem_rd     = 1'b0;
        addr_pc    = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        load_A     = 1'b0;
        load_B     = 1'b0;
        wb_A       = 1'b0;
        wr_mem     = 1'b0;
        imm        = 1'b0;
        jmp        = 1'b0;
        ret        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;
        fault_code = 2'b00;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    if (en) begin
                        mem_rd  = 1'b1;
                        addr_pc = 1'b1;
                        ir_load = mem_ready;
                        pc_inc  = mem_ready;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_JMP) begin
                        jmp        = 1'b1;
                        push       = 1'b1;
                        instr_done = 1'b1;
                    end else if (op_q == OP_RET) begin
                        ret        = 1'b1;
                        pop        = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    if (op_q == OP_STORE) begin
                        wr_mem     = 1'b1;
                        instr_done = mem_ready;
                    end else begin
                        mem_rd = 1'b1;
                    end
                end
                S_WB: begin
                    instr_done = 1'b1;
                    case (op_q)
                        OP_LOAD_A: load_A = 1'b1;
                        OP_LOAD_B: load_B = 1'b1;
                        OP_LOAD_IMM: begin
                            imm    = 1'b1;
                            load_A = sel_q;
                            load_B = !sel_q;
                        end
                        OP_ALU:  wb_A = 1'b1;
                        default: ;
                    endcase
                end
                S_FAULT: begin
                    fault      = fault_q;
                    fault_code = fault_code_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench: each row gives opcode, mem_ready and the full expected output vector.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst, en, sel, mem_ready;
    logic [2:0] opcode;
    logic       mem_rd, addr_pc, ir_load, pc_inc, load_A, load_B, wb_A, wr_mem;
    logic       imm, jmp, ret, push, pop, instr_done, fault;
    logic [1:0] fault_code;
    logic [16:0] o;
    int passed = 0;
    int total  = 0;

    localparam logic [16:0] RD   = 17'd1 << 16;
    localparam logic [16:0] PC   = 17'd1 << 15;
    localparam logic [16:0] IR   = 17'd1 << 14;
    localparam logic [16:0] INC  = 17'd1 << 13;
    localparam logic [16:0] LA   = 17'd1 << 12;
    localparam logic [16:0] LB   = 17'd1 << 11;
    localparam logic [16:0] WBA  = 17'd1 << 10;
    localparam logic [16:0] WR   = 17'd1 << 9;
    localparam logic [16:0] IMM  = 17'd1 << 8;
    localparam logic [16:0] JMP  = 17'd1 << 7;
    localparam logic [16:0] RET  = 17'd1 << 6;
    localparam logic [16:0] PSH  = 17'd1 << 5;
    localparam logic [16:0] POP  = 17'd1 << 4;
    localparam logic [16:0] DONE = 17'd1 << 3;
    localparam logic [16:0] FLT  = 17'd1 << 2;
    localparam logic [16:0] FOK  = RD | PC | IR | INC;
    localparam logic [16:0] NONE = 17'd0;

    typedef struct packed {
        logic [2:0]  op;
        logic        rdy;
        logic [16:0] exp;
    } row_t;

    multicycle_control_unit #(.STACK_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .sel(sel), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .addr_pc(addr_pc), .ir_load(ir_load), .pc_inc(pc_inc),
        .load_A(load_A), .load_B(load_B), .wb_A(wb_A), .wr_mem(wr_mem), .imm(imm),
        .jmp(jmp), .ret(ret), .push(push), .pop(pop), .instr_done(instr_done),
        .fault(fault), .fault_code(fault_code)
    );

    assign o = {mem_rd, addr_pc, ir_load, pc_inc, load_A, load_B, wb_A, wr_mem, imm,
                jmp, ret, push, pop, instr_done, fault, fault_code};

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mem_ready = 1'b0; opcode = 3'b000; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mem_ready = 1'b1; opcode = 3'b010; sel = 1'b0;
        @(negedge clk);
        total++;
        if (o !== NONE) $display("FAIL reset_outputs: got %b want %b", o, NONE); else passed++;
        @(posedge clk); #1 rst = 1'b0; en = 1'b0;
        @(negedge clk);
        total++;
        if (o !== NONE) $display("FAIL reset_idle: got %b want %b", o, NONE); else passed++;
        @(posedge clk); #1 en = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (o !== (RD | PC)) $display("FAIL reset_fetch: got %b want %b", o, RD | PC); else passed++;
    endtask

    task automatic test_load_imm();
        row_t q[$];
        do_reset();
        en = 1'b1; sel = 1'b1;
        q.push_back(row_t'({3'b010, 1'b1, FOK}));
        q.push_back(row_t'({3'b010, 1'b1, NONE}));
        q.push_back(row_t'({3'b010, 1'b1, IMM | LA | DONE}));
        q.push_back(row_t'({3'b010, 1'b1, FOK}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL load_imm cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        row_t q[$];
        do_reset();
        en = 1'b1;
        q.push_back(row_t'({3'b000, 1'b1, FOK}));
        q.push_back(row_t'({3'b000, 1'b0, NONE}));
        q.push_back(row_t'({3'b000, 1'b0, RD}));
        q.push_back(row_t'({3'b000, 1'b0, RD}));
        q.push_back(row_t'({3'b000, 1'b0, RD}));
        q.push_back(row_t'({3'b000, 1'b1, RD}));
        q.push_back(row_t'({3'b000, 1'b0, LA | DONE}));
        q.push_back(row_t'({3'b000, 1'b0, RD | PC}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL load_wait cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t q[$];
        do_reset();
        en = 1'b1; sel = 1'b0;
        q.push_back(row_t'({3'b111, 1'b1, FOK}));
        q.push_back(row_t'({3'b111, 1'b1, NONE}));
        q.push_back(row_t'({3'b111, 1'b1, NONE}));
        q.push_back(row_t'({3'b111, 1'b1, WBA | DONE}));
        q.push_back(row_t'({3'b011, 1'b1, FOK}));
        q.push_back(row_t'({3'b011, 1'b1, NONE}));
        q.push_back(row_t'({3'b011, 1'b1, WR | DONE}));
        q.push_back(row_t'({3'b001, 1'b1, FOK}));
        q.push_back(row_t'({3'b001, 1'b1, NONE}));
        q.push_back(row_t'({3'b001, 1'b1, RD}));
        q.push_back(row_t'({3'b001, 1'b1, LB | DONE}));
        q.push_back(row_t'({3'b010, 1'b1, FOK}));
        q.push_back(row_t'({3'b010, 1'b1, NONE}));
        q.push_back(row_t'({3'b010, 1'b1, IMM | LB | DONE}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL back_to_back cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stack_overflow();
        row_t q[$];
        do_reset();
        en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            q.push_back(row_t'({3'b100, 1'b1, FOK}));
            q.push_back(row_t'({3'b100, 1'b1, NONE}));
            q.push_back(row_t'({3'b100, 1'b1, JMP | PSH | DONE}));
        end
        q.push_back(row_t'({3'b100, 1'b1, FOK}));
        q.push_back(row_t'({3'b100, 1'b1, NONE}));
        for (int j = 0; j < 3; j++) q.push_back(row_t'({3'b100, 1'b1, FLT | 17'b10}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL stack_overflow cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_call_ret();
        row_t q[$];
        do_reset();
        en = 1'b1;
        q.push_back(row_t'({3'b100, 1'b1, FOK}));
        q.push_back(row_t'({3'b100, 1'b1, NONE}));
        q.push_back(row_t'({3'b100, 1'b1, JMP | PSH | DONE}));
        q.push_back(row_t'({3'b110, 1'b1, FOK}));
        q.push_back(row_t'({3'b110, 1'b1, NONE}));
        q.push_back(row_t'({3'b110, 1'b1, RET | POP | DONE}));
        q.push_back(row_t'({3'b110, 1'b1, FOK}));
        q.push_back(row_t'({3'b110, 1'b1, NONE}));
        q.push_back(row_t'({3'b110, 1'b1, FLT | 17'b10}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL call_ret cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        row_t q[$];
        do_reset();
        en = 1'b1;
        q.push_back(row_t'({3'b101, 1'b1, FOK}));
        q.push_back(row_t'({3'b101, 1'b1, NONE}));
        q.push_back(row_t'({3'b101, 1'b1, FLT | 17'b01}));
        q.push_back(row_t'({3'b000, 1'b1, FLT | 17'b01}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL illegal cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        row_t q[$];
        do_reset();
        en = 1'b1;
        for (int j = 0; j < 16; j++) q.push_back(row_t'({3'b010, 1'b0, RD | PC}));
        q.push_back(row_t'({3'b010, 1'b1, FLT | 17'b11}));
        q.push_back(row_t'({3'b010, 1'b1, FLT | 17'b11}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL timeout cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
        q.delete();
        do_reset();
        en = 1'b1; sel = 1'b0;
        for (int j = 0; j < 15; j++) q.push_back(row_t'({3'b010, 1'b0, RD | PC}));
        q.push_back(row_t'({3'b010, 1'b1, FOK}));
        q.push_back(row_t'({3'b010, 1'b0, NONE}));
        q.push_back(row_t'({3'b010, 1'b0, IMM | LB | DONE}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL ready_at_limit cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_store();
        row_t q[$];
        do_reset();
        en = 1'b1;
        q.push_back(row_t'({3'b100, 1'b1, FOK}));
        q.push_back(row_t'({3'b100, 1'b1, NONE}));
        q.push_back(row_t'({3'b100, 1'b1, JMP | PSH | DONE}));
        q.push_back(row_t'({3'b011, 1'b1, FOK}));
        q.push_back(row_t'({3'b011, 1'b0, NONE}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL mid_store_setup cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (o !== WR) $display("FAIL mid_store_wr: got %b want %b", o, WR); else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (o !== NONE) $display("FAIL async_reset_drop: got %b want %b", o, NONE); else passed++;
        @(posedge clk); #1 rst = 1'b0; en = 1'b0; mem_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            total++;
            if (o !== NONE) $display("FAIL en_low_idle cyc%0d: got %b want %b", j, o, NONE); else passed++;
            @(posedge clk); #1;
        end
        q.delete();
        en = 1'b1;
        q.push_back(row_t'({3'b110, 1'b1, FOK}));
        q.push_back(row_t'({3'b110, 1'b1, NONE}));
        q.push_back(row_t'({3'b110, 1'b1, FLT | 17'b10}));
        foreach (q[i]) begin
            opcode = q[i].op; mem_ready = q[i].rdy;
            @(negedge clk);
            total++;
            if (o !== q[i].exp) $display("FAIL depth_cleared cyc%0d: got %b want %b", i + 1, o, q[i].exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_load_wait();
        test_back_to_back();
        test_stack_overflow();
        test_call_ret();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
